// File: rtl/pipeline_processor.sv
// pipeline_processor
// ------------------
// Minimal 4-stage (IF, ID, EX, WB) in-order 8-bit processor. The program, the
// data and the register state all live inside the block: benches preload and
// inspect instruction_memory and register_file hierarchically.
//
// Ports:
//   clk  - single clock, every state update happens on its rising edge
//   rst  - synchronous, active-high reset. Clears the PC and all pipeline
//          valid bits. Memory and register contents are left untouched.
//
// Instruction word: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
//   00 ADD   rd <= rs1 + rs2
//   01 SUB   rd <= rs1 - rs2
//   10 LOAD  rd <= mem[rs1]
//   11 STORE mem[rs1] <= rs2
//   0x00 is a NOP (no writeback).
//
// Hazards are resolved without stalls:
//   - ID captures the WB value when WB writes the register being read.
//   - EX takes an operand from EX/WB when that entry writes the register it
//     names. This is the newest value and overrides the ID/EX copy.
//
// Optional build macro: PIPELINE_TRACE_EN
//   When defined, every register writeback and every STORE is printed.
//   Behaviour is identical with or without the macro.
module pipeline_processor #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int NUM_REGS  = 4
) (
    input logic clk,
    input logic rst
);

    localparam int REG_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } opcode_t;

    logic [DATA_W-1:0] instruction_memory [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] register_file      [0:NUM_REGS-1];

    // IF stage and IF/ID register
    logic [DATA_W-1:0] pc;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;

    // ID/EX register
    logic              id_valid;
    opcode_t           id_op;
    logic              id_we;
    logic [REG_W-1:0]  id_rd;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic [DATA_W-1:0] id_a;
    logic [DATA_W-1:0] id_b;

    // EX/WB register
    logic              wb_valid;
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_result;

    // Decode of the IF/ID word
    opcode_t           dec_op;
    logic [REG_W-1:0]  dec_rd;
    logic [REG_W-1:0]  dec_rs1;
    logic [REG_W-1:0]  dec_rs2;
    logic              dec_we;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;

    // EX datapath
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_result;
    logic              wb_write;
    logic              store_en;

    // The WB stage writes the register file on the coming edge.
    assign wb_write = wb_valid && wb_we;

    always_comb begin
        dec_op  = opcode_t'(if_instr[7:6]);
        dec_rd  = if_instr[5:4];
        dec_rs1 = if_instr[3:2];
        dec_rs2 = if_instr[1:0];
        // STORE never writes a register; the all-zero word is a NOP.
        dec_we  = (dec_op != OP_STORE) && (if_instr != '0);

        // Read-during-write: the register file update lands at the same edge
        // ID captures its operands, so take the WB value directly.
        dec_a = register_file[dec_rs1];
        dec_b = register_file[dec_rs2];
        if (wb_write && (wb_rd == dec_rs1)) dec_a = wb_result;
        if (wb_write && (wb_rd == dec_rs2)) dec_b = wb_result;
    end

    always_comb begin
        // EX/WB holds the instruction directly ahead; its result is newer
        // than anything captured in ID/EX.
        ex_a = id_a;
        ex_b = id_b;
        if (wb_write && (wb_rd == id_rs1)) ex_a = wb_result;
        if (wb_write && (wb_rd == id_rs2)) ex_b = wb_result;

        ex_result = '0;
        case (id_op)
            OP_ADD:   ex_result = ex_a + ex_b;
            OP_SUB:   ex_result = ex_a - ex_b;
            OP_LOAD:  ex_result = instruction_memory[ex_a];
            OP_STORE: ex_result = ex_b;
            default:  ex_result = '0;
        endcase

        // A STORE caught by a reset edge is discarded like any other
        // in-flight instruction.
        store_en = id_valid && (id_op == OP_STORE) && !rst;
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            if_valid  <= 1'b0;
            if_instr  <= '0;
            id_valid  <= 1'b0;
            id_op     <= OP_ADD;
            id_we     <= 1'b0;
            id_rd     <= '0;
            id_rs1    <= '0;
            id_rs2    <= '0;
            id_a      <= '0;
            id_b      <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_result <= '0;
        end else begin
            // IF: PC wraps naturally at the top of the 8-bit address space
            pc       <= pc + DATA_W'(1);
            if_valid <= 1'b1;
            if_instr <= instruction_memory[pc];

            // ID
            id_valid <= if_valid;
            id_op    <= dec_op;
            id_we    <= dec_we;
            id_rd    <= dec_rd;
            id_rs1   <= dec_rs1;
            id_rs2   <= dec_rs2;
            id_a     <= dec_a;
            id_b     <= dec_b;

            // EX
            wb_valid  <= id_valid;
            wb_we     <= id_we;
            wb_rd     <= id_rd;
            wb_result <= ex_result;
        end
    end

    // Register file: no reset so preloaded contents survive.
    always_ff @(posedge clk) begin
        if (!rst && wb_write) begin
            register_file[wb_rd] <= wb_result;
        end
    end

    // Unified memory: STORE writes at the end of EX. Later fetches of the
    // same address see the new word; already-fetched words are not patched.
    always_ff @(posedge clk) begin
        if (store_en) begin
            instruction_memory[ex_a] <= ex_b;
        end
    end

`ifdef PIPELINE_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && wb_write) begin
            $display("[%0t] WB  r%0d <= 0x%02h", $time, wb_rd, wb_result);
        end
        if (store_en) begin
            $display("[%0t] ST  mem[0x%02h] <= 0x%02h", $time, ex_a, ex_b);
        end
    end
`else
`endif

endmodule

// File: tb/tb_pipeline_processor.sv
// tb_pipeline_processor
// ---------------------
// Directed bench for pipeline_processor. Each scenario preloads memory and
// registers while reset is held, releases reset and runs a fixed number of
// cycles. Every register writeback is matched against a queue of expected
// {edge, rd, value} entries; final register/memory state is checked directly.
module tb_pipeline_processor;

    localparam int W = 18;  // {edge[7:0], rd[1:0], value[7:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    logic [W-1:0] exp_q[$];

    pipeline_processor dut (
        .clk(clk),
        .rst(rst)
    );

    // Clock / reset bookkeeping
    always #5 clk = ~clk;

    // Edge 1 is the first rising edge after reset release.
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Checkers
    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard
    task automatic push_exp(input int e, input int rd, input int val);
        exp_q.push_back({8'(e), 2'(rd), 8'(val)});
    endtask

    // Sampled on the falling edge: a pending write lands on the next edge.
    task automatic check_wb();
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        if (!rst && dut.wb_write) begin
            obs = {8'(edge_cnt + 1), dut.wb_rd, dut.wb_result};
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL wb_write: observed edge=%0d r%0d=0x%02h expected edge=%0d r%0d=0x%02h",
                       obs[17:10], obs[9:8], obs[7:0], exp[17:10], exp[9:8], exp[7:0]);
            end
        end
    endtask

    // Driver tasks
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check_wb();
        end
    endtask

    // Leaves rst high after at least one reset edge with memory cleared to NOPs.
    task automatic start_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 256; i++) dut.instruction_memory[i] = 8'h00;
        @(negedge clk);
    endtask

    task automatic set_regs(input logic [7:0] r0, r1, r2, r3);
        dut.register_file[0] = r0;
        dut.register_file[1] = r1;
        dut.register_file[2] = r2;
        dut.register_file[3] = r3;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] r0, r1, r2, r3);
        check8({tag, "_r0"}, dut.register_file[0], r0);
        check8({tag, "_r1"}, dut.register_file[1], r1);
        check8({tag, "_r2"}, dut.register_file[2], r2);
        check8({tag, "_r3"}, dut.register_file[3], r3);
    endtask

    task automatic load_add_program();
        dut.instruction_memory[0]  = 8'h90;  // LOAD R1,[R0]
        dut.instruction_memory[1]  = 8'hA0;  // LOAD R2,[R0]
        dut.instruction_memory[2]  = 8'h36;  // ADD  R3,R1,R2
        dut.instruction_memory[10] = 8'd50;
        dut.instruction_memory[11] = 8'd25;
    endtask

    // Stimulus
    initial begin
        // Reset state
        start_reset();
        check8("reset_pc", dut.pc, 8'h00);
        check8("reset_if_valid", {7'd0, dut.if_valid}, 8'h00);
        check8("reset_wb_valid", {7'd0, dut.wb_valid}, 8'h00);

        // Load/add chain with forwarding
        set_regs(8'd11, 8'd0, 8'd0, 8'd0);
        load_add_program();
        push_exp(4, 1, 25);
        push_exp(5, 2, 25);
        push_exp(6, 3, 50);
        rst = 1'b0;
        run(9);
        check_regs("load_add", 8'd11, 8'd25, 8'd25, 8'd50);
        check_int("load_add_pending", exp_q.size(), 0);

        // SUB with wrap
        start_reset();
        set_regs(8'd0, 8'd5, 8'd7, 8'd0);
        dut.instruction_memory[0] = 8'h76;  // SUB R3,R1,R2
        push_exp(4, 3, 254);
        rst = 1'b0;
        run(8);
        check_regs("sub_wrap", 8'd0, 8'd5, 8'd7, 8'd254);
        check_int("sub_pending", exp_q.size(), 0);

        // STORE then LOAD of the same address
        start_reset();
        set_regs(8'd20, 8'h5A, 8'd0, 8'd0);
        dut.instruction_memory[0] = 8'hC1;  // STORE [R0],R1
        dut.instruction_memory[1] = 8'hA0;  // LOAD  R2,[R0]
        push_exp(5, 2, 8'h5A);
        rst = 1'b0;
        run(2);
        check8("store_before_edge3", dut.instruction_memory[20], 8'h00);
        run(1);
        check8("store_after_edge3", dut.instruction_memory[20], 8'h5A);
        run(5);
        check8("store_load_r2", dut.register_file[2], 8'h5A);
        check_int("store_pending", exp_q.size(), 0);

        // Back-to-back dependencies
        start_reset();
        set_regs(8'd1, 8'd0, 8'd0, 8'd0);
        dut.instruction_memory[0] = 8'h10;  // ADD R1,R0,R0
        dut.instruction_memory[1] = 8'h25;  // ADD R2,R1,R1
        dut.instruction_memory[2] = 8'h39;  // ADD R3,R2,R1
        push_exp(4, 1, 2);
        push_exp(5, 2, 4);
        push_exp(6, 3, 6);
        rst = 1'b0;
        run(8);
        check_regs("b2b", 8'd1, 8'd2, 8'd4, 8'd6);
        check_int("b2b_pending", exp_q.size(), 0);

        // Reset while the load/add chain is in EX, then restart from PC=0
        start_reset();
        set_regs(8'd11, 8'd0, 8'd0, 8'd0);
        load_add_program();
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_regs("mid_reset", 8'd11, 8'd0, 8'd0, 8'd0);
        check8("mid_reset_pc", dut.pc, 8'h00);
        push_exp(4, 1, 25);
        push_exp(5, 2, 25);
        push_exp(6, 3, 50);
        rst = 1'b0;
        run(9);
        check_regs("restart", 8'd11, 8'd25, 8'd25, 8'd50);
        check_int("restart_pending", exp_q.size(), 0);

        // STORE sitting in EX at a reset edge must not write
        start_reset();
        set_regs(8'd20, 8'h5A, 8'd0, 8'd0);
        dut.instruction_memory[0] = 8'hC1;
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        @(negedge clk);
        check8("store_in_reset", dut.instruction_memory[20], 8'h00);

        // PC wrap over all-NOP memory
        start_reset();
        set_regs(8'd3, 8'd4, 8'd5, 8'd6);
        rst = 1'b0;
        run(255);
        check8("pc_at_255", dut.pc, 8'd255);
        run(1);
        check8("pc_wrap_0", dut.pc, 8'd0);
        run(4);
        check8("pc_after_260", dut.pc, 8'd4);
        check_regs("nop_run", 8'd3, 8'd4, 8'd5, 8'd6);
        check_int("nop_pending", exp_q.size(), 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
